store_align_buffer: RTL and testbench
=====================================

Name: store_align_buffer

Overview:
- Write-side counterpart of the WB-stage load extender: takes MEM-stage store requests (SB/SH/SW) and produces word-aligned address, lane-replicated data and byte strobes.
- Queues them in a small FIFO and drains them to the data bus over a valid/ready handshake.
- Exposes a load-address hazard check so the pipeline can stall loads that hit a pending store.

Parameters:
DEPTH, 4, number of buffered stores; power of two, >= 2
CNT_W, $clog2(DEPTH)+1, width of occupancy count

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
MEM_StoreValid  in  1  committed store request this cycle
MEM_StoreAddr  in  32  byte address of store
MEM_StoreData  in  32  store data, right-justified (rt value)
MEM_StoreSize  in  2  00=byte, 01=half, 10=word, 11=reserved
MEM_Flush  in  1  kills the request presented this cycle
MEM_StoreAccept  out  1  request enqueued this cycle (combinational)
MEM_AddrErr  out  1  misaligned or reserved-size request (combinational)
MEM_LoadAddr  in  32  address of load currently in MEM
MEM_LoadHit  out  1  a buffered store targets the same word (combinational)
Bus_WrValid  out  1  head entry presented to bus
Bus_WrAddr  out  32  word-aligned address {addr[31:2],2'b00}
Bus_WrData  out  32  lane-replicated data
Bus_WrStrb  out  4  byte enables, bit i = byte lane i
Bus_WrReady  in  1  bus accepts the presented entry
Buf_Count  out  CNT_W  current occupancy
Buf_Empty  out  1  Buf_Count == 0

Behaviour:
- Reset (asynchronous, any cycle, including mid-transfer): read/write pointers and count = 0; all entries discarded. Bus_WrValid=0, Bus_WrAddr/Data/Strb=0, Buf_Count=0, Buf_Empty=1. An in-flight unacknowledged write is dropped.
- Alignment check:
  - MEM_AddrErr = MEM_StoreValid & !MEM_Flush & (size==11 | (size==01 & addr[0]) | (size==10 & addr[1:0]!=0)).
- Entry formation:
  - byte: strb = 4'b0001 << addr[1:0], data = {4{d[7:0]}}.
  - half: strb = addr[1] ? 1100 : 0011, data = {2{d[15:0]}}.
  - word: strb = 1111, data = d.
  - Stored address is word-aligned.
- Enqueue:
  - MEM_StoreAccept = MEM_StoreValid & !MEM_Flush & !MEM_AddrErr & (Buf_Count != DEPTH).
  - When full, the request is not accepted, even if a dequeue happens the same cycle; the pipeline must hold and retry.
- No bypass:
  - A store accepted into an empty buffer appears on the bus the next cycle. Enqueue-to-Bus_WrValid latency is 1 cycle.
- Drain:
  - Bus_WrValid = !Buf_Empty. Addr/Data/Strb always reflect the head entry.
  - Head values stay stable while Bus_WrValid & !Bus_WrReady.
  - Dequeue on Bus_WrValid & Bus_WrReady.
- Count update:
  - Simultaneous enqueue and dequeue leaves Buf_Count unchanged; both pointers advance.
  - Pointers wrap modulo DEPTH.
- Order: strict FIFO; bus writes occur in acceptance order.
- Flush: affects only the current-cycle request. Entries already buffered are committed and always drain.
- Load hazard:
  - MEM_LoadHit = 1 if any valid entry's addr[31:2] == MEM_LoadAddr[31:2], regardless of strobes.
  - Excludes the store being accepted in the same cycle.
  - Excludes an entry being dequeued in the same cycle only once its dequeue has taken effect, i.e. it still counts in the dequeue cycle.
- Bus_WrReady asserted while Bus_WrValid=0 is ignored.

Test Plan:
- Reset, then SB addr=0x8000_0003 data=0x1234_5678, Bus_WrReady=1 -> next cycle Bus_WrValid=1, Addr=0x8000_0000, Data=0x7878_7878, Strb=1000; count returns to 0 the cycle after.
- SH addr=0x8000_0012 data=0xAAAA_BEEF -> Addr=0x8000_0010, Data=0xBEEF_BEEF, Strb=1100. SW addr=0x8000_0020 -> Strb=1111, data unchanged.
- SW addr=0x8000_0001, SH addr=0x8000_0003, size=11 -> MEM_AddrErr=1, MEM_StoreAccept=0, Buf_Count stays 0, no bus write.
- Bus_WrReady=0, issue 5 back-to-back SW (0x100,0x104,0x108,0x10C,0x110):
  - Accept=1 for the first 4, 0 for the 5th; Buf_Count=4.
  - Head Addr stays 0x100 stable.
  - Raise Ready -> writes 0x100..0x10C in order.
  - Retried 0x110 is accepted the cycle after the first dequeue, not the same cycle.
- Full buffer with Ready=1 and a new store in the same cycle -> not accepted; count goes 4->3. Non-full simultaneous enq/deq -> count unchanged.
- Pending SB to 0x200, MEM_LoadAddr=0x203 -> LoadHit=1; LoadAddr=0x204 -> 0. MEM_Flush=1 with a valid store -> Accept=0. Assert rst with 3 entries pending and Ready=0 -> Bus_WrValid=0, Buf_Count=0 immediately.

Source files
------------

// File: rtl/store_align_buffer.sv
// Store alignment buffer: turns MEM-stage SB/SH/SW requests into word-aligned,
// lane-replicated bus writes, queues them in a FIFO and flags load-address hazards.
module store_align_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MEM_StoreValid,
    input  logic [31:0]      MEM_StoreAddr,
    input  logic [31:0]      MEM_StoreData,
    input  logic [1:0]       MEM_StoreSize,
    input  logic             MEM_Flush,
    output logic             MEM_StoreAccept,
    output logic             MEM_AddrErr,
    input  logic [31:0]      MEM_LoadAddr,
    output logic             MEM_LoadHit,
    output logic             Bus_WrValid,
    output logic [31:0]      Bus_WrAddr,
    output logic [31:0]      Bus_WrData,
    output logic [3:0]       Bus_WrStrb,
    input  logic             Bus_WrReady,
    output logic [CNT_W-1:0] Buf_Count,
    output logic             Buf_Empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [29:0]      addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [3:0]       strb_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             enq;
    logic             deq;
    logic [31:0]      fmt_data;
    logic [3:0]       fmt_strb;
    logic [PTR_W-1:0] idx;
    logic             unused_load_lsb;

    assign unused_load_lsb = ^MEM_LoadAddr[1:0];

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    assign MEM_AddrErr = MEM_StoreValid & ~MEM_Flush &
                         ((MEM_StoreSize == 2'b11) |
                          ((MEM_StoreSize == 2'b01) & MEM_StoreAddr[0]) |
                          ((MEM_StoreSize == 2'b10) & (MEM_StoreAddr[1:0] != 2'b00)));

    // Full blocks acceptance even when the head drains this same cycle.
    assign enq = MEM_StoreValid & ~MEM_Flush & ~MEM_AddrErr & ~full;
    assign deq = ~empty & Bus_WrReady;
    assign MEM_StoreAccept = enq;

    always_comb begin
        fmt_data = MEM_StoreData;
        fmt_strb = 4'b1111;
        case (MEM_StoreSize)
            2'b00: begin
                fmt_data = {4{MEM_StoreData[7:0]}};
                fmt_strb = 4'b0001 << MEM_StoreAddr[1:0];
            end
            2'b01: begin
                fmt_data = {2{MEM_StoreData[15:0]}};
                fmt_strb = MEM_StoreAddr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                fmt_data = MEM_StoreData;
                fmt_strb = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[wr_ptr] <= MEM_StoreAddr[31:2];
            data_mem[wr_ptr] <= fmt_data;
            strb_mem[wr_ptr] <= fmt_strb;
        end
    end

    // Only occupied slots participate; a store accepted this cycle is not yet stored.
    always_comb begin
        MEM_LoadHit = 1'b0;
        idx         = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if ((CNT_W'(k) < count) && (addr_mem[idx] == MEM_LoadAddr[31:2]))
                MEM_LoadHit = 1'b1;
        end
    end

    assign Bus_WrValid = ~empty;
    assign Bus_WrAddr  = empty ? 32'h0 : {addr_mem[rd_ptr], 2'b00};
    assign Bus_WrData  = empty ? 32'h0 : data_mem[rd_ptr];
    assign Bus_WrStrb  = empty ? 4'h0  : strb_mem[rd_ptr];
    assign Buf_Count   = count;
    assign Buf_Empty   = empty;
endmodule

// File: tb/tb_store_align_buffer.sv
// Scoreboard bench for store_align_buffer: expected bus writes are queued when a
// store is issued and compared in order as the DUT hands them to the bus.
module tb_store_align_buffer;
    logic        clk;
    logic        rst;
    logic        MEM_StoreValid;
    logic [31:0] MEM_StoreAddr;
    logic [31:0] MEM_StoreData;
    logic [1:0]  MEM_StoreSize;
    logic        MEM_Flush;
    logic        MEM_StoreAccept;
    logic        MEM_AddrErr;
    logic [31:0] MEM_LoadAddr;
    logic        MEM_LoadHit;
    logic        Bus_WrValid;
    logic [31:0] Bus_WrAddr;
    logic [31:0] Bus_WrData;
    logic [3:0]  Bus_WrStrb;
    logic        Bus_WrReady;
    logic [2:0]  Buf_Count;
    logic        Buf_Empty;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    wr_t sb[$];
    int  checks   = 0;
    int  failures = 0;

    store_align_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .MEM_StoreValid(MEM_StoreValid), .MEM_StoreAddr(MEM_StoreAddr),
        .MEM_StoreData(MEM_StoreData), .MEM_StoreSize(MEM_StoreSize),
        .MEM_Flush(MEM_Flush), .MEM_StoreAccept(MEM_StoreAccept),
        .MEM_AddrErr(MEM_AddrErr), .MEM_LoadAddr(MEM_LoadAddr),
        .MEM_LoadHit(MEM_LoadHit), .Bus_WrValid(Bus_WrValid),
        .Bus_WrAddr(Bus_WrAddr), .Bus_WrData(Bus_WrData),
        .Bus_WrStrb(Bus_WrStrb), .Bus_WrReady(Bus_WrReady),
        .Buf_Count(Buf_Count), .Buf_Empty(Buf_Empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic wr_t formEntry(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        wr_t e;
        e.addr = {a[31:2], 2'b00};
        case (sz)
            2'b00: begin
                e.data = {d[7:0], d[7:0], d[7:0], d[7:0]};
                case (a[1:0])
                    2'd0: e.strb = 4'b0001;
                    2'd1: e.strb = 4'b0010;
                    2'd2: e.strb = 4'b0100;
                    default: e.strb = 4'b1000;
                endcase
            end
            2'b01: begin
                e.data = {d[15:0], d[15:0]};
                e.strb = (a[1] == 1'b1) ? 4'b1100 : 4'b0011;
            end
            default: begin
                e.data = d;
                e.strb = 4'b1111;
            end
        endcase
        return e;
    endfunction

    // Called at posedge+1; checks combinational outputs mid-cycle, returns at next posedge+1.
    task automatic applyStimulus(input logic v, input logic [1:0] sz, input logic [31:0] a,
                                 input logic [31:0] d, input logic fl, input logic [31:0] la,
                                 input logic expAcc, input logic expErr, input logic expHit);
        MEM_StoreValid = v;
        MEM_StoreSize  = sz;
        MEM_StoreAddr  = a;
        MEM_StoreData  = d;
        MEM_Flush      = fl;
        MEM_LoadAddr   = la;
        @(negedge clk);
        checkOutput("accept", {31'b0, MEM_StoreAccept}, {31'b0, expAcc});
        checkOutput("addr_err", {31'b0, MEM_AddrErr}, {31'b0, expErr});
        checkOutput("load_hit", {31'b0, MEM_LoadHit}, {31'b0, expHit});
        if (expAcc)
            sb.push_back(formEntry(a, d, sz));
        @(posedge clk);
        #1;
        MEM_StoreValid = 1'b0;
        MEM_Flush      = 1'b0;
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (!Buf_Empty && n < 50) begin
            idleCycle();
            n++;
        end
        checkOutput("drain_empty", {31'b0, Buf_Empty}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst && Bus_WrValid && Bus_WrReady) begin
            checkOutput("wr_expected_pending", {31'b0, (sb.size() > 0)}, 32'd1);
            if (sb.size() > 0) begin
                wr_t e;
                e = sb.pop_front();
                checkOutput("wr_addr", Bus_WrAddr, e.addr);
                checkOutput("wr_data", Bus_WrData, e.data);
                checkOutput("wr_strb", {28'b0, Bus_WrStrb}, {28'b0, e.strb});
            end
        end
    end

    initial begin
        rst = 1'b1;
        MEM_StoreValid = 1'b0;
        MEM_StoreAddr  = '0;
        MEM_StoreData  = '0;
        MEM_StoreSize  = 2'b00;
        MEM_Flush      = 1'b0;
        MEM_LoadAddr   = '0;
        Bus_WrReady    = 1'b1;
        #3;
        checkOutput("rst_valid", {31'b0, Bus_WrValid}, 32'd0);
        checkOutput("rst_count", {29'b0, Buf_Count}, 32'd0);
        checkOutput("rst_empty", {31'b0, Buf_Empty}, 32'd1);
        checkOutput("rst_addr", Bus_WrAddr, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] byte/half/word formatting");
        applyStimulus(1'b1, 2'b00, 32'h8000_0003, 32'h1234_5678, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("sb_count1", {29'b0, Buf_Count}, 32'd1);
        checkOutput("sb_valid", {31'b0, Bus_WrValid}, 32'd1);
        idleCycle();
        checkOutput("sb_count0", {29'b0, Buf_Count}, 32'd0);
        applyStimulus(1'b1, 2'b01, 32'h8000_0012, 32'hAAAA_BEEF, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b10, 32'h8000_0020, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        waitDrain();

        $display("[TB] misaligned and reserved sizes");
        applyStimulus(1'b1, 2'b10, 32'h8000_0001, 32'h1111_1111, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b01, 32'h8000_0003, 32'h2222_2222, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b11, 32'h8000_0000, 32'h3333_3333, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("err_count", {29'b0, Buf_Count}, 32'd0);

        $display("[TB] fill, backpressure, full retry");
        Bus_WrReady = 1'b0;
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 2'b10, 32'h100 + 32'(i * 4), 32'hD000_0100 + 32'(i * 4), 1'b0, 32'h0,
                          (i < 4), 1'b0, 1'b0);
        checkOutput("full_count", {29'b0, Buf_Count}, 32'd4);
        checkOutput("head_addr", Bus_WrAddr, 32'h100);
        idleCycle();
        checkOutput("head_addr_hold", Bus_WrAddr, 32'h100);
        checkOutput("head_data_hold", Bus_WrData, 32'hD000_0100);
        Bus_WrReady = 1'b1;
        applyStimulus(1'b1, 2'b10, 32'h110, 32'hD000_0110, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("full_deq_count", {29'b0, Buf_Count}, 32'd3);
        applyStimulus(1'b1, 2'b10, 32'h110, 32'hD000_0110, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("enq_deq_count", {29'b0, Buf_Count}, 32'd3);
        waitDrain();

        $display("[TB] load hazard and flush");
        Bus_WrReady = 1'b0;
        applyStimulus(1'b1, 2'b00, 32'h200, 32'h0000_00A5, 1'b0, 32'h200, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h203, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h204, 1'b0, 1'b0, 1'b0);
        Bus_WrReady = 1'b1;
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h200, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h200, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b10, 32'h300, 32'h7777_7777, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b10, 32'h301, 32'h7777_7777, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("flush_count", {29'b0, Buf_Count}, 32'd0);

        $display("[TB] reset with pending entries");
        Bus_WrReady = 1'b0;
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 2'b10, 32'h400 + 32'(i * 4), 32'hE000_0000 + 32'(i), 1'b0, 32'h0,
                          1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", {31'b0, Bus_WrValid}, 32'd0);
        checkOutput("mid_rst_count", {29'b0, Buf_Count}, 32'd0);
        checkOutput("mid_rst_empty", {31'b0, Buf_Empty}, 32'd1);
        checkOutput("mid_rst_data", Bus_WrData, 32'h0);
        checkOutput("mid_rst_strb", {28'b0, Bus_WrStrb}, 32'h0);
        sb.delete();
        #2;
        rst = 1'b0;
        idleCycle();
        Bus_WrReady = 1'b1;
        applyStimulus(1'b1, 2'b10, 32'h500, 32'h55AA_55AA, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        waitDrain();
        idleCycle();
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
